// File: rtl/spi_pkg.sv
// spi_pkg: shared constants and types for the SPI target.
//   DATA_W_DEF      default bits per SPI frame
//   SYNC_STAGES_DEF default synchroniser depth on SPI pins
//   state_t         frame FSM states (IDLE, ACTIVE)
//   SPI_MODE0       {CPOL, CPHA} of the supported mode
//   IDLE_MISO       level driven on miso outside a frame
package spi_pkg;

  localparam int DATA_W_DEF      = 8;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // {CPOL, CPHA}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic       IDLE_MISO = 1'b0;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchroniser for one asynchronous SPI pin with
// single-cycle rise/fall pulses derived from the synchronised value.
// Ports:
//   clk     system clock
//   rst     synchronous active-high reset
//   i_async asynchronous pin
//   o_rise  1-cycle pulse on synchronised 0->1
//   o_fall  1-cycle pulse on synchronised 1->0
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_sync;

  assign w_sync = r_sync[SYNC_STAGES-1];

  // Synchroniser chain plus one history flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= w_sync;
    end
  end

  assign o_rise = w_sync & ~r_prev;
  assign o_fall = ~w_sync & r_prev;

endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0, MSB-first byte-serial target. SPI pins are
// oversampled by clk; sclk is never used as a clock.
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   sclk, mosi, cs      SPI pins from the master (cs active-low)
//   miso                serial data to the master
//   tx_data/valid/ready one-entry transmit buffer write port
//   rx_data, rx_valid   last received byte and its 1-cycle update pulse
//   busy                frame active (synchronised cs low)
//   underrun            1-cycle pulse: shifter loaded from an empty buffer
//   abort               1-cycle pulse: frame ended on a partial byte
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              cs,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              underrun,
  output logic              abort
);

  localparam int              CNT_W      = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic             SCLK_IDLE = SPI_MODE0[1];

  state_t                 r_state;
  state_t                 w_state_next;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   w_mosi_s;
  logic                   w_sclk_rise;
  logic                   w_sclk_fall;
  logic                   w_cs_rise;
  logic                   w_cs_fall;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic [DATA_W-1:0]      r_rx_shift;
  logic                   r_rx_done;
  logic [DATA_W-1:0]      r_tx_shift;
  logic [DATA_W-1:0]      r_buf;
  logic                   r_buf_full;
  logic                   r_miso;
  logic [DATA_W-1:0]      r_rx_data;
  logic                   r_rx_valid;
  logic                   r_underrun;
  logic                   r_abort;
  logic                   w_load;
  logic                   w_wr;
  logic [DATA_W-1:0]      w_load_data;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(SCLK_IDLE)) u_sclk_sync (
    .clk    (clk),
    .rst    (rst),
    .i_async(sclk),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk    (clk),
    .rst    (rst),
    .i_async(cs),
    .o_rise (w_cs_rise),
    .o_fall (w_cs_fall)
  );

  // mosi only needs to be aligned with the synchronised sclk, no edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mosi_sync <= {SYNC_STAGES{1'b0}};
    end else begin
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
    end
  end

  assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

  // Frame state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and shifter-load decode. A cs fall in IDLE takes priority
  // over any sclk edge in the same cycle because sclk is only acted on in
  // ACTIVE; a cs rise likewise masks a coincident sclk fall.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cs_fall) begin
          w_state_next = ACTIVE;
          w_load       = 1'b1;
        end else begin
          w_state_next = IDLE;
        end
      end
      ACTIVE: begin
        if (w_cs_rise) begin
          w_state_next = IDLE;
        end else if (w_sclk_fall && (r_bit_cnt == CNT_ZERO)) begin
          w_load = 1'b1;
        end else begin
          w_load = 1'b0;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign w_load_data = r_buf_full ? r_buf : {DATA_W{1'b0}};
  assign w_wr        = tx_valid & ~r_buf_full;

  // One-entry tx buffer. A load from an empty buffer does not block a
  // simultaneous write; that byte is kept for the next load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf      <= {DATA_W{1'b0}};
      r_buf_full <= 1'b0;
    end else if (w_load && r_buf_full) begin
      r_buf_full <= 1'b0;
    end else if (w_wr) begin
      r_buf      <= tx_data;
      r_buf_full <= 1'b1;
    end
  end

  // Shifters, bit counter and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt  <= CNT_ZERO;
      r_rx_shift <= {DATA_W{1'b0}};
      r_rx_done  <= 1'b0;
      r_tx_shift <= {DATA_W{1'b0}};
      r_miso     <= IDLE_MISO;
      r_rx_data  <= {DATA_W{1'b0}};
      r_rx_valid <= 1'b0;
      r_underrun <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_underrun <= 1'b0;
      r_abort    <= 1'b0;
      r_rx_done  <= 1'b0;
      // Completed byte is published one cycle after its last bit lands.
      if (r_rx_done) begin
        r_rx_data  <= r_rx_shift;
        r_rx_valid <= 1'b1;
      end
      if (r_state == IDLE) begin
        if (w_cs_fall) begin
          r_bit_cnt  <= CNT_ZERO;
          r_tx_shift <= w_load_data;
          r_miso     <= w_load_data[DATA_W-1];
          r_underrun <= ~r_buf_full;
        end
      end else if (w_cs_rise) begin
        r_abort   <= (r_bit_cnt != CNT_ZERO);
        r_bit_cnt <= CNT_ZERO;
        r_miso    <= IDLE_MISO;
      end else begin
        if (w_sclk_rise) begin
          r_rx_shift <= {r_rx_shift[DATA_W-2:0], w_mosi_s};
          if (r_bit_cnt == CNT_MAX) begin
            r_bit_cnt <= CNT_ZERO;
            r_rx_done <= 1'b1;
          end else begin
            r_bit_cnt <= r_bit_cnt + CNT_ONE;
          end
        end
        if (w_sclk_fall) begin
          if (w_load) begin
            r_tx_shift <= w_load_data;
            r_miso     <= w_load_data[DATA_W-1];
            r_underrun <= ~r_buf_full;
          end else begin
            r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
            r_miso     <= r_tx_shift[DATA_W-2];
          end
        end
      end
    end
  end

  assign miso     = r_miso;
  assign tx_ready = ~r_buf_full;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign busy     = (r_state == ACTIVE);
  assign underrun = r_underrun;
  assign abort    = r_abort;

endmodule
